rf_operand_fetch: RTL and testbench

- Decode/operand-fetch stage that acts as the initiator of the MIPS register file.
- Accepts instructions over a valid/ready handshake, drives the register file's two read addresses, and bypasses same-cycle writebacks.
- Tracks pending destination writes in a 32-bit scoreboard and stalls on RAW/WAW hazards.
- Forwards writebacks onto the register file write port and presents registered operands to execute.

---
 rtl/rf_operand_fetch.sv | 184 ++++++++++++++++++
 tb/tb_rf_operand_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rf_operand_fetch
// Brief    : MIPS decode/operand-fetch stage. Drives the register file read
//            and write ports, bypasses same-cycle writebacks, tracks pending
//            destinations in a 32-entry scoreboard, stalls on RAW/WAW hazards
//            and on a full in-flight window, and registers the operand
//            bundle for execute.
// Revision : 1.0 - initial release
// ============================================================================
module rf_operand_fetch #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic [4:0]  o_raddr1,
  output logic [4:0]  o_raddr2,
  input  logic [31:0] i_rdata1,
  input  logic [31:0] i_rdata2,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_op_valid,
  input  logic        i_op_ready,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic [4:0]  o_op_dest,
  output logic [31:0] o_op_instr,
  output logic        o_wb_err
);

  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // Registered state
  logic [31:0]      busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      a_q,     a_d;
  logic [31:0]      b_q,     b_d;
  logic [4:0]       dest_q,  dest_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q,   err_d;

  // Decode and hazard wires
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd, dest;
  logic             rt_used;
  logic             hit_rs, hit_rt, hit_dest;
  logic             beff_rs, beff_rt, beff_dest;
  logic             wb_clr;
  logic [CNT_W-1:0] cnt_eff;
  logic             stall;
  logic             issue;
  logic             dest_set;
  logic [31:0]      opnd_a, opnd_b;

  // Decode source/destination fields from the offered instruction
  always_comb begin
    opcode  = i_instr[31:26];
    rs      = i_instr[25:21];
    rt      = i_instr[20:16];
    rd      = i_instr[15:11];
    dest    = 5'd0;
    rt_used = 1'b0;
    case (opcode)
      6'h00:                      dest = rd;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23:                      dest = rt;
      6'h03:                      dest = 5'd31;
      default:                    dest = 5'd0;
    endcase
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B: rt_used = 1'b1;
      default:                    rt_used = 1'b0;
    endcase
  end

  // Register file ports: reads follow the instruction, writes follow writeback
  always_comb begin
    o_raddr1   = i_instr[25:21];
    o_raddr2   = i_instr[20:16];
    o_rf_we    = i_wb_valid && (i_wb_addr != 5'd0);
    o_rf_waddr = i_wb_addr;
    o_rf_wdata = i_wb_data;
  end

  // Bypass selection, effective busy state and stall/handshake generation
  always_comb begin
    hit_rs    = i_wb_valid && (i_wb_addr == rs)   && (rs   != 5'd0);
    hit_rt    = i_wb_valid && (i_wb_addr == rt)   && (rt   != 5'd0);
    hit_dest  = i_wb_valid && (i_wb_addr == dest) && (dest != 5'd0);
    beff_rs   = busy_q[rs]   && !hit_rs;
    beff_rt   = busy_q[rt]   && !hit_rt;
    beff_dest = busy_q[dest] && !hit_dest;

    opnd_a = (rs == 5'd0) ? 32'd0 : (hit_rs ? i_wb_data : i_rdata1);
    opnd_b = (rt == 5'd0) ? 32'd0 : (hit_rt ? i_wb_data : i_rdata2);

    // r0 is never marked busy, so a writeback to r0 never clears anything
    wb_clr  = i_wb_valid && busy_q[i_wb_addr];
    cnt_eff = cnt_q - {{(CNT_W-1){1'b0}}, wb_clr};

    stall = beff_rs
         || (rt_used && beff_rt)
         || ((dest != 5'd0) && (beff_dest || (cnt_eff == C_MAX_CNT)));

    o_instr_ready = !stall && (!valid_q || i_op_ready);
    issue         = i_instr_valid && o_instr_ready;
    dest_set      = issue && (dest != 5'd0);
  end

  // Next-state for scoreboard, counter and the execute bundle
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) begin
      busy_d[i_wb_addr] = 1'b0;
    end
    // Applied after the clear so a same-register set wins
    if (dest_set) begin
      busy_d[dest] = 1'b1;
    end
    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, wb_clr} + {{(CNT_W-1){1'b0}}, dest_set};

    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    instr_d = instr_q;
    if (issue) begin
      valid_d = 1'b1;
      a_d     = opnd_a;
      b_d     = opnd_b;
      dest_d  = dest;
      instr_d = i_instr;
    end else if (valid_q && i_op_ready) begin
      valid_d = 1'b0;
    end

    err_d = i_wb_valid && !wb_clr;
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q  <= 32'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      dest_q  <= 5'd0;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Registered outputs to execute
  always_comb begin
    o_op_valid = valid_q;
    o_op_a     = a_q;
    o_op_b     = b_q;
    o_op_dest  = dest_q;
    o_op_instr = instr_q;
    o_wb_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_operand_fetch
// Brief    : Self-checking bench for rf_operand_fetch: directed hazard
//            scenarios followed by randomized traffic against a reference
//            model of the scoreboard, handshake and operand bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_operand_fetch;

  localparam int C_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b, op_instr;
  logic [4:0]  op_dest;
  logic        wb_err;

  always #5 clk = ~clk;

  // Register file contents owned by the bench
  logic [31:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  rf_operand_fetch #(.MAX_INFLIGHT(C_MAX), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_instr_valid(instr_valid), .i_instr(instr), .o_instr_ready(instr_ready),
    .o_raddr1(raddr1), .o_raddr2(raddr2), .i_rdata1(rdata1), .i_rdata2(rdata2),
    .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_op_valid(op_valid), .i_op_ready(op_ready),
    .o_op_a(op_a), .o_op_b(op_b), .o_op_dest(op_dest), .o_op_instr(op_instr),
    .o_wb_err(wb_err)
  );

  // Reference model state
  bit          m_busy [32];
  int          m_cnt;
  bit          m_valid;
  logic [31:0] m_a, m_b, m_instr;
  logic [4:0]  m_dest;
  bit          m_err;

  int n_checks = 0;
  int n_errors = 0;
  logic last_ready, last_we;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int dest_of(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    if (op == 0) return int'(ins[15:11]);
    if ((op >= 8 && op <= 15) || op == 35) return int'(ins[20:16]);
    if (op == 3) return 31;
    return 0;
  endfunction

  function automatic bit rt_is_src(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    return (op == 0 || op == 4 || op == 5 || op == 43);
  endfunction

  // One clock of stimulus plus checks of both combinational and registered outputs
  task automatic step(input logic v, input logic [31:0] ins, input logic wv,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic ordy, input logic r);
    int rs, rt, d;
    bit hrs, hrt, hd, brs, brt, bd, clr, stl, rdy, iss;
    int ceff;
    logic [31:0] ea, eb;
    @(negedge clk);
    instr_valid = v; instr = ins; wb_valid = wv; wb_addr = wa; wb_data = wd;
    op_ready = ordy; rst = r;
    #1;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); d = dest_of(ins);
    hrs = wv && int'(wa) == rs && rs != 0;
    hrt = wv && int'(wa) == rt && rt != 0;
    hd  = wv && int'(wa) == d  && d  != 0;
    brs = m_busy[rs] && !hrs;
    brt = m_busy[rt] && !hrt;
    bd  = m_busy[d]  && !hd;
    clr = wv && wa != 5'd0 && m_busy[wa];
    ceff = m_cnt - (clr ? 1 : 0);
    stl = brs || (rt_is_src(ins) && brt) || (d != 0 && (bd || ceff == C_MAX));
    rdy = !stl && (!m_valid || ordy);
    iss = v && rdy && !r;
    ea = (rs == 0) ? 32'd0 : (hrs ? wd : rf[rs]);
    eb = (rt == 0) ? 32'd0 : (hrt ? wd : rf[rt]);

    check("raddr1", {27'd0, raddr1}, 32'(rs));
    check("raddr2", {27'd0, raddr2}, 32'(rt));
    check("rf_we", {31'd0, rf_we}, {31'd0, wv && wa != 5'd0});
    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
    check("rf_wdata", rf_wdata, wd);
    check("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
    last_ready = instr_ready;
    last_we    = rf_we;

    if (r) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_cnt = 0; m_valid = 0; m_a = 0; m_b = 0; m_dest = 0; m_instr = 0; m_err = 0;
    end else begin
      m_err = wv && !clr;
      if (clr) begin m_busy[wa] = 1'b0; m_cnt--; end
      if (iss) begin
        if (d != 0) begin m_busy[d] = 1'b1; m_cnt++; end
        m_valid = 1; m_a = ea; m_b = eb; m_dest = 5'(d); m_instr = ins;
      end else if (m_valid && ordy) begin
        m_valid = 0;
      end
    end

    @(posedge clk);
    #1;
    if (wv && wa != 5'd0) rf[wa] = wd;
    check("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("op_dest", {27'd0, op_dest}, {27'd0, m_dest});
    check("op_instr", op_instr, m_instr);
    check("wb_err", {31'd0, wb_err}, {31'd0, m_err});
  endtask

  function automatic logic [31:0] addiu(input int rt, input int rs);
    return {6'h09, 5'(rs), 5'(rt), 16'h0001};
  endfunction

  localparam logic [31:0] C_ADDU3 = 32'h0022_1821;  // addu $3,$1,$2
  localparam logic [31:0] C_ADDU4 = 32'h0063_2021;  // addu $4,$3,$3
  localparam logic [31:0] C_SW    = 32'hAC22_0000;  // sw $2,0($1)

  initial begin
    int ops [8] = '{0, 8, 35, 3, 4, 43, 2, 15};
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    rf[1] = 32'd5; rf[2] = 32'd7;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt = 0; m_valid = 0; m_a = 0; m_b = 0; m_dest = 0; m_instr = 0; m_err = 0;
    rst = 1; instr_valid = 0; instr = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 1;

    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Basic issue with register file operands
    step(1, C_ADDU3, 0, 0, 0, 1, 0);
    check("dir_a5", op_a, 32'd5);
    check("dir_b7", op_b, 32'd7);
    check("dir_dest3", {27'd0, op_dest}, 32'd3);

    // RAW stall, then bypass from same-cycle writeback
    step(1, C_ADDU4, 0, 0, 0, 1, 0);
    check("dir_raw_stall", {31'd0, last_ready}, 32'd0);
    step(1, C_ADDU4, 1, 5'd3, 32'h1234, 1, 0);
    check("dir_bypass_ready", {31'd0, last_ready}, 32'd1);
    check("dir_bypass_we", {31'd0, last_we}, 32'd1);
    check("dir_bypass_a", op_a, 32'h1234);
    check("dir_bypass_b", op_b, 32'h1234);

    // Fill the in-flight window
    step(1, addiu(5, 0), 0, 0, 0, 1, 0);
    step(1, addiu(6, 0), 0, 0, 0, 1, 0);
    step(1, addiu(7, 0), 0, 0, 0, 1, 0);
    step(1, addiu(8, 0), 0, 0, 0, 1, 0);
    check("dir_full_stall", {31'd0, last_ready}, 32'd0);
    step(1, C_SW, 0, 0, 0, 1, 0);
    check("dir_sw_issue", {31'd0, last_ready}, 32'd1);
    step(1, addiu(8, 0), 1, 5'd4, 32'hAA, 1, 0);
    check("dir_unblock", {31'd0, last_ready}, 32'd1);

    // Backpressure from execute
    for (int i = 0; i < 3; i++) begin
      step(1, C_SW, 0, 0, 0, 0, 0);
      check("dir_hold_ready", {31'd0, last_ready}, 32'd0);
      check("dir_hold_dest", {27'd0, op_dest}, 32'd8);
    end
    step(1, C_SW, 0, 0, 0, 1, 0);
    check("dir_release", op_instr, C_SW);

    // Writebacks to non-busy registers
    step(0, 0, 1, 5'd9, 32'h99, 1, 0);
    check("dir_err9_we", {31'd0, last_we}, 32'd1);
    check("dir_err9", {31'd0, wb_err}, 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("dir_err_pulse", {31'd0, wb_err}, 32'd0);
    step(0, 0, 1, 5'd0, 32'h77, 1, 0);
    check("dir_err0_we", {31'd0, last_we}, 32'd0);
    check("dir_err0", {31'd0, wb_err}, 32'd1);

    // Reset with pending state
    step(1, addiu(9, 0), 1, 5'd5, 32'h55, 0, 0);
    step(1, addiu(10, 0), 0, 0, 0, 0, 0);
    check("dir_pre_rst_stall", {31'd0, last_ready}, 32'd0);
    step(1, addiu(10, 0), 0, 0, 0, 0, 1);
    check("dir_rst_valid", {31'd0, op_valid}, 32'd0);
    step(1, addiu(10, 0), 0, 0, 0, 1, 0);
    check("dir_post_rst", {31'd0, last_ready}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int q [$];
      logic [31:0] ins;
      logic [4:0] wa;
      ins = {6'(ops[$urandom_range(7)]), 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), 11'($urandom)};
      for (int i = 0; i < 32; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(9) < 8) wa = 5'(q[$urandom_range(q.size() - 1)]);
      else wa = 5'($urandom_range(9));
      step($urandom_range(9) < 7, ins, $urandom_range(9) < 4, wa, $urandom,
           $urandom_range(9) < 7, $urandom_range(299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
